// File: rtl/axi_crossbar_wr_scheduler.sv
// rtl/axi_crossbar_wr_scheduler.sv - per-slave AXI write scheduler: round-robin AW grant, AW/W/B phase enables
// Define AXI_CROSSBAR_WR_BWAIT_EN to hold the grant through the B handshake (RESP state).
module axi_crossbar_wr_scheduler #(
  parameter int AXI_REQUEST_NUM = 3
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [AXI_REQUEST_NUM-1:0] s_awvalid_i,
  input  logic                       m_awready_i,
  input  logic                       m_wvalid_i,
  input  logic                       m_wready_i,
  input  logic                       m_wlast_i,
  input  logic                       m_bvalid_i,
  input  logic                       m_bready_i,
  output logic [AXI_REQUEST_NUM-1:0] grant_o,
  output logic                       aw_en_o,
  output logic                       w_en_o,
  output logic                       b_en_o,
  output logic                       busy_o
);

  localparam logic [AXI_REQUEST_NUM-1:0] ONE = AXI_REQUEST_NUM'(1);

`ifdef AXI_CROSSBAR_WR_BWAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
`endif

  state_t                       state_q, state_d;
  logic [AXI_REQUEST_NUM-1:0]   grant_q, grant_d;
  logic [AXI_REQUEST_NUM-1:0]   ptr_q, ptr_d;
  logic [AXI_REQUEST_NUM-1:0]   hi_mask, req_hi, win_oh, ptr_next;
  logic                         aw_fire, w_last_fire;

  // Requests at or above ptr win first (isolate lowest set bit); otherwise wrap to the lowest request.
  assign hi_mask  = ~(ptr_q - ONE);
  assign req_hi   = s_awvalid_i & hi_mask;
  assign win_oh   = (|req_hi) ? (req_hi & (~req_hi + ONE))
                              : (s_awvalid_i & (~s_awvalid_i + ONE));
  assign ptr_next = {win_oh[AXI_REQUEST_NUM-2:0], win_oh[AXI_REQUEST_NUM-1]};

  assign aw_fire     = (|(s_awvalid_i & grant_q)) & m_awready_i;
  assign w_last_fire = m_wvalid_i & m_wready_i & m_wlast_i;

`ifdef AXI_CROSSBAR_WR_BWAIT_EN
  logic b_fire;
  assign b_fire = m_bvalid_i & m_bready_i;
`else
  logic unused_b;
  assign unused_b = m_bvalid_i ^ m_bready_i;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= ONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    aw_en_o = 1'b0;
    w_en_o  = 1'b0;
    b_en_o  = 1'b0;
    busy_o  = 1'b1;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (|s_awvalid_i) begin
          state_d = ADDR;
          grant_d = win_oh;
          ptr_d   = ptr_next;
        end
      end
      ADDR: begin
        aw_en_o = 1'b1;
        if (aw_fire) state_d = DATA;
      end
      DATA: begin
        w_en_o = 1'b1;
        if (w_last_fire) begin
`ifdef AXI_CROSSBAR_WR_BWAIT_EN
          state_d = RESP;
`else
          state_d = IDLE;
          grant_d = '0;
`endif
        end
      end
`ifdef AXI_CROSSBAR_WR_BWAIT_EN
      RESP: begin
        b_en_o = 1'b1;
        if (b_fire) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_axi_crossbar_wr_scheduler.sv
// tb/tb_axi_crossbar_wr_scheduler.sv - self-checking bench for axi_crossbar_wr_scheduler
module tb_axi_crossbar_wr_scheduler;

  localparam int N = 3;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [N-1:0] s_awvalid_i = '0;
  logic         m_awready_i = 1'b0;
  logic         m_wvalid_i = 1'b0;
  logic         m_wready_i = 1'b0;
  logic         m_wlast_i = 1'b0;
  logic         m_bvalid_i = 1'b0;
  logic         m_bready_i = 1'b0;
  logic [N-1:0] grant_o;
  logic         aw_en_o, w_en_o, b_en_o, busy_o;

  axi_crossbar_wr_scheduler #(.AXI_REQUEST_NUM(N)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .s_awvalid_i(s_awvalid_i), .m_awready_i(m_awready_i),
    .m_wvalid_i(m_wvalid_i), .m_wready_i(m_wready_i), .m_wlast_i(m_wlast_i),
    .m_bvalid_i(m_bvalid_i), .m_bready_i(m_bready_i), .grant_o(grant_o),
    .aw_en_o(aw_en_o), .w_en_o(w_en_o), .b_en_o(b_en_o), .busy_o(busy_o)
  );

  always #5 ACLK = ~ACLK;

`ifdef AXI_CROSSBAR_WR_BWAIT_EN
  localparam bit BWAIT = 1'b1;
`else
  localparam bit BWAIT = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] aw;
    logic         awr, wv, wr, wl, bv, br;
    logic [N-1:0] g;
    logic         aw_en, w_en, b_en, busy;
  } vec_t;
  vec_t vecs[$];

  // Transaction-level reference: who owns the slave, which phase it is in, who has priority.
  int m_owner;   // -1 when nobody holds the slave
  int m_phase;   // 0 idle, 1 address, 2 data, 3 response
  int m_prio;

  function automatic logic [N+3:0] outs();
    return {grant_o, aw_en_o, w_en_o, b_en_o, busy_o};
  endfunction

  function automatic logic [N+3:0] model_outs();
    logic [N-1:0] g;
    g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    return {g, m_phase == 1, m_phase == 2, m_phase == 3, m_phase != 0};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_phase = 0;
    m_prio  = 0;
  endtask

  task automatic model_edge();
    case (m_phase)
      0: begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_prio + k) % N;
          if (m_phase == 0 && s_awvalid_i[idx]) begin
            m_owner = idx;
            m_phase = 1;
            m_prio  = (idx + 1) % N;
          end
        end
      end
      1: if (s_awvalid_i[m_owner] && m_awready_i) m_phase = 2;
      2: if (m_wvalid_i && m_wready_i && m_wlast_i) begin
        if (BWAIT) m_phase = 3;
        else begin m_phase = 0; m_owner = -1; end
      end
      default: if (m_bvalid_i && m_bready_i) begin m_phase = 0; m_owner = -1; end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] aw, input logic awr, input logic wv, input logic wr,
                       input logic wl, input logic bv, input logic br);
    s_awvalid_i = aw; m_awready_i = awr; m_wvalid_i = wv; m_wready_i = wr;
    m_wlast_i = wl; m_bvalid_i = bv; m_bready_i = br;
  endtask

  function automatic vec_t mk(input logic [N-1:0] g, input logic a, input logic w, input logic b,
                              input logic bz);
    vec_t v;
    v.aw = 3'b111; v.awr = 1; v.wv = 1; v.wr = 1; v.wl = 1; v.bv = 1; v.br = 1;
    v.g = g; v.aw_en = a; v.w_en = w; v.b_en = b; v.busy = bz;
    return v;
  endfunction

  initial begin
    logic [N-1:0] gseq[4];
    logic [N-1:0] g_hold;
    int w_cnt;
    logic ok;

    gseq[0] = 3'b001; gseq[1] = 3'b010; gseq[2] = 3'b100; gseq[3] = 3'b001;
    foreach (gseq[i]) begin
      vecs.push_back(mk(gseq[i], 1, 0, 0, 1));
      vecs.push_back(mk(gseq[i], 0, 1, 0, 1));
      if (BWAIT) vecs.push_back(mk(gseq[i], 0, 0, 1, 1));
      vecs.push_back(mk('0, 0, 0, 0, 0));
    end

    // Reset held with every request and ready high: outputs stay quiet.
    drive(3'b111, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_quiet", 32'(outs()), 32'(0));
    end
    ARESET = 1'b0;

    // Contention with immediate readies, single-beat bursts.
    foreach (vecs[i]) begin
      drive(vecs[i].aw, vecs[i].awr, vecs[i].wv, vecs[i].wr, vecs[i].wl, vecs[i].bv, vecs[i].br);
      step();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vecs[i].g, vecs[i].aw_en, vecs[i].w_en, vecs[i].b_en, vecs[i].busy}));
    end

    // 4-beat burst from master 1 with a stall on beat 2.
    ARESET = 1'b1; #1; ARESET = 1'b0;
    drive(3'b010, 1, 0, 0, 0, 0, 0);
    step();
    chk("burst_grant", 32'(grant_o), 32'(3'b010));
    g_hold = grant_o;
    step();
    chk("burst_data", 32'(w_en_o), 32'(1));
    w_cnt = 0;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(3'b000, 0, 1, (c != 1), (c == 4), 0, 0);
      if (w_en_o) w_cnt++;
      if (grant_o !== g_hold) ok = 1'b0;
      step();
    end
    chk("burst_w_cycles", 32'(w_cnt), 32'(5));
    chk("burst_grant_stable", 32'(ok), 32'(1));
    chk("burst_after_last", 32'(outs()),
        BWAIT ? 32'({3'b010, 4'b0011}) : 32'(0));
    if (BWAIT) begin
      drive(3'b000, 0, 0, 0, 0, 1, 0);
      step();
      chk("resp_hold", 32'(outs()), 32'({3'b010, 4'b0011}));
      drive(3'b000, 0, 0, 0, 0, 1, 1);
      step();
      chk("resp_done", 32'(outs()), 32'(0));
    end

    // Asynchronous reset in DATA, then master 2 alone.
    drive(3'b001, 1, 0, 0, 0, 1, 1);
    step();
    step();
    chk("mid_in_data", 32'(w_en_o), 32'(1));
    ARESET = 1'b1;
    #1;
    chk("mid_reset_now", 32'(outs()), 32'(0));
    step();
    ARESET = 1'b0;
    drive(3'b100, 0, 0, 0, 0, 0, 0);
    step();
    chk("mid_regrant", 32'(outs()), 32'({3'b100, 4'b1001}));

    // Randomized run against the reference model.
    ARESET = 1'b1;
    model_reset();
    step();
    ARESET = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      chk("rand", 32'(outs()), 32'(model_outs()));
      drive(N'($urandom), ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
            ($urandom % 3) == 0, $urandom % 2, $urandom % 2);
      if (($urandom % 64) == 0) begin
        ARESET = 1'b1;
        model_reset();
      end else begin
        ARESET = 1'b0;
        model_edge();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
